// File: rtl/multithread_register_file.sv
// Multi-thread register file with a sequential clear engine (full clear after reset, per-thread clear on request).
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module multithread_register_file #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [REG_INDEX_BITS+THREAD_INDEX_BITS-1:0] reg_access_raddr,
  output logic [DATA_WIDTH-1:0]                     reg_access_rdata,
  input  logic [REG_INDEX_BITS+THREAD_INDEX_BITS-1:0] reg_access_waddr,
  input  logic [DATA_WIDTH-1:0]                     reg_access_wdata,
  input  logic                                      reg_access_we,
  input  logic                                      in_clear_valid,
  input  logic [THREAD_INDEX_BITS-1:0]              in_clear_thread_index,
  output logic                                      out_clear_ready,
  output logic                                      out_ready,
  output logic                                      out_write_dropped
);

  localparam int AW = REG_INDEX_BITS + THREAD_INDEX_BITS;
  localparam int N  = 1 << AW;

  typedef enum logic [1:0] {INIT, IDLE, TCLR} state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic [THREAD_INDEX_BITS-1:0] thread_q, thread_d;
  logic                         dropped_q, dropped_d;

  logic                  memWe;
  logic [AW-1:0]         memAddr;
  logic [DATA_WIDTH-1:0] memData;
  logic [DATA_WIDTH-1:0] mem [N];

  logic [THREAD_INDEX_BITS-1:0] readThread;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      thread_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      thread_q  <= thread_d;
      dropped_q <= dropped_d;
    end
  end

  // The single write port is shared: the clear engine owns it outside IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    thread_d  = thread_q;
    dropped_d = reg_access_we && (state_q != IDLE);
    memWe     = 1'b0;
    memAddr   = reg_access_waddr;
    memData   = reg_access_wdata;
    case (state_q)
      INIT: begin
        memWe   = 1'b1;
        memAddr = cnt_q;
        memData = '0;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        memWe = reg_access_we;
        if (in_clear_valid && out_clear_ready) begin
          thread_d = in_clear_thread_index;
          cnt_d    = '0;
          state_d  = TCLR;
        end
      end
      TCLR: begin
        memWe   = 1'b1;
        memAddr = {thread_q, cnt_q[REG_INDEX_BITS-1:0]};
        memData = '0;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q[REG_INDEX_BITS-1:0]) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && memWe) mem[memAddr] <= memData;
  end

  assign readThread = reg_access_raddr[AW-1 -: THREAD_INDEX_BITS];

  // Entries not yet cleared read as zero, so stale data never leaks out.
  always_comb begin
    reg_access_rdata = mem[reg_access_raddr];
    if (state_q == INIT) begin
      reg_access_rdata = '0;
    end else if (state_q == TCLR && readThread == thread_q) begin
      reg_access_rdata = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (state_q == IDLE && reg_access_we && reg_access_waddr == reg_access_raddr) begin
      reg_access_rdata = reg_access_wdata;
    end
`endif
  end

  assign out_ready         = (state_q == IDLE);
  assign out_clear_ready   = (state_q == IDLE) && !rst;
  assign out_write_dropped = dropped_q;

endmodule

// File: tb/tb_multithread_register_file.sv
// Directed self-checking bench for multithread_register_file (default parameters).
module tb_multithread_register_file;

  logic        clk;
  logic        rst;
  logic [7:0]  raddr;
  logic [63:0] rdata;
  logic [7:0]  waddr;
  logic [63:0] wdata;
  logic        we;
  logic        clearValid;
  logic [2:0]  clearThread;
  logic        clearReady;
  logic        ready;
  logic        dropped;

  int vectors = 0;
  int miscompares = 0;

  multithread_register_file dut (
    .clk                   (clk),
    .rst                   (rst),
    .reg_access_raddr      (raddr),
    .reg_access_rdata      (rdata),
    .reg_access_waddr      (waddr),
    .reg_access_wdata      (wdata),
    .reg_access_we         (we),
    .in_clear_valid        (clearValid),
    .in_clear_thread_index (clearThread),
    .out_clear_ready       (clearReady),
    .out_ready             (ready),
    .out_write_dropped     (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr, input logic [63:0] expected);
    raddr = addr;
    #1;
    checkOutput(tag, rdata, expected);
  endtask

  initial begin
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = 1'b0;
    clearValid = 1'b0; clearThread = '0;

    // Reset state
    repeat (3) applyStimulus();
    checkOutput("rst_ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_clear_ready", {63'd0, clearReady}, 64'd0);
    checkOutput("rst_dropped", {63'd0, dropped}, 64'd0);
    readCheck("rst_rdata", 8'h10, 64'd0);

    // Full clear takes 256 edges with rst low
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      applyStimulus();
      checkOutput("init_ready", {63'd0, ready}, (i == 256) ? 64'd1 : 64'd0);
      if (i == 100) readCheck("init_rdata", 8'h55, 64'd0);
    end
    checkOutput("init_done_clear_ready", {63'd0, clearReady}, 64'd1);
    for (int a = 0; a < 256; a++) readCheck("init_zero", 8'(a), 64'd0);

    // Basic write then read
    we = 1'b1; waddr = 8'h67; wdata = 64'hDEAD_BEEF_0000_0001;
    applyStimulus();
    we = 1'b0;
    readCheck("wr_3_7", 8'h67, 64'hDEAD_BEEF_0000_0001);
    readCheck("rd_2_7", 8'h47, 64'd0);

    // Same-cycle write and read of {1,4}
    we = 1'b1; waddr = 8'h24; wdata = 64'h11;
    applyStimulus();
    wdata = 64'h55;
`ifdef REG_FILE_BYPASS_EN
    readCheck("same_cycle_rd", 8'h24, 64'h55);
`else
    readCheck("same_cycle_rd", 8'h24, 64'h11);
`endif
    applyStimulus();
    we = 1'b0;
    readCheck("after_wr_rd", 8'h24, 64'h55);

    // Fill threads 2 and 5, plus {0,1}
    for (int r = 0; r < 32; r++) begin
      we = 1'b1; waddr = {3'd2, 5'(r)}; wdata = 64'h2000 + 64'(r);
      applyStimulus();
      waddr = {3'd5, 5'(r)}; wdata = 64'h5000 + 64'(r);
      applyStimulus();
    end
    waddr = 8'h01; wdata = 64'hAB;
    applyStimulus();
    we = 1'b0;
    readCheck("fill_5_3", 8'hA3, 64'h5003);

    // Thread-5 clear, with a dropped write in the middle
    clearValid = 1'b1; clearThread = 3'd5;
    #1;
    checkOutput("tclr_accept_ready", {63'd0, clearReady}, 64'd1);
    applyStimulus();
    clearValid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checkOutput("tclr_ready", {63'd0, ready}, 64'd0);
      checkOutput("tclr_clear_ready", {63'd0, clearReady}, 64'd0);
      readCheck("tclr_rd_t5", {3'd5, 5'(k)}, 64'd0);
      readCheck("tclr_rd_t2", {3'd2, 5'(k)}, 64'h2000 + 64'(k));
      if (k == 4) begin
        we = 1'b1; waddr = 8'h01; wdata = 64'h99;
      end
      applyStimulus();
      if (k == 4) begin
        we = 1'b0;
        checkOutput("drop_pulse", {63'd0, dropped}, 64'd1);
      end
      if (k == 5) checkOutput("drop_clear", {63'd0, dropped}, 64'd0);
    end
    checkOutput("tclr_done_ready", {63'd0, ready}, 64'd1);
    checkOutput("tclr_done_clear_ready", {63'd0, clearReady}, 64'd1);
    for (int r = 0; r < 32; r++) begin
      readCheck("post_t5", {3'd5, 5'(r)}, 64'd0);
      readCheck("post_t2", {3'd2, 5'(r)}, 64'h2000 + 64'(r));
    end
    readCheck("post_0_1", 8'h01, 64'hAB);
    readCheck("post_3_7", 8'h67, 64'hDEAD_BEEF_0000_0001);
    readCheck("post_1_4", 8'h24, 64'h55);

    // Reset at cycle 10 of a thread-2 clear
    clearValid = 1'b1; clearThread = 3'd2;
    applyStimulus();
    clearValid = 1'b0;
    repeat (10) applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_clear_ready", {63'd0, clearReady}, 64'd0);
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst_mid_ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_mid_dropped", {63'd0, dropped}, 64'd0);
    for (int i = 1; i <= 256; i++) begin
      applyStimulus();
      checkOutput("reinit_ready", {63'd0, ready}, (i == 256) ? 64'd1 : 64'd0);
      if (i == 1) readCheck("reinit_rdata", 8'h67, 64'd0);
    end
    for (int a = 0; a < 256; a++) readCheck("reinit_zero", 8'(a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multithread_register_file.md
# multithread_register_file

Multi-thread register file that serves the `reg_access_*` port of the decode stage. It is the responder end of that interface. It holds 2^(REG_INDEX_BITS+THREAD_INDEX_BITS) words, addressed as `{thread, reg}`, with an asynchronous read port and a synchronous write port driven by writeback. A sequential clear engine zeroes the whole array after reset, and zeroes one thread's 2^REG_INDEX_BITS registers on a valid/ready request.

## Interface
- `DATA_WIDTH`, 64, width of each register
- `REG_INDEX_BITS`, 5, register index bits per thread
- `THREAD_INDEX_BITS`, 3, thread index bits
- `clk`  input  1  clock; all state changes on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `reg_access_raddr`  input  REG_INDEX_BITS+THREAD_INDEX_BITS  read address `{thread, reg}`
- `reg_access_rdata`  output  DATA_WIDTH  read data, combinational from raddr
- `reg_access_waddr`  input  REG_INDEX_BITS+THREAD_INDEX_BITS  write address `{thread, reg}`
- `reg_access_wdata`  input  DATA_WIDTH  write data
- `reg_access_we`  input  1  write enable
- `in_clear_valid`  input  1  thread-clear request
- `in_clear_thread_index`  input  THREAD_INDEX_BITS  thread to clear
- `out_clear_ready`  output  1  a thread-clear request can be accepted
- `out_ready`  output  1  array initialised and no clear is in progress
- `out_write_dropped`  output  1  one-cycle pulse: a write was discarded because a clear owned the port

## Operation
- Storage has N = 2^(REG_INDEX_BITS+THREAD_INDEX_BITS) entries. The clear counter `cnt` is REG_INDEX_BITS+THREAD_INDEX_BITS bits wide.
- FSM states:
  - INIT: full clear.
  - IDLE: normal operation.
  - TCLR: thread clear.
- INIT:
  - Entered while `rst`=1.
  - Each edge with `rst`=0 writes 0 to entry `cnt`, then increments `cnt`.
  - The edge that writes entry N-1 moves the FSM to IDLE.
- IDLE:
  - When `reg_access_we`=1, `mem[waddr]` ← `wdata`.
  - When `in_clear_valid` && `out_clear_ready`, latch the thread index, set `cnt`=0, and go to TCLR.
- TCLR:
  - Each edge writes 0 to `{thread, cnt[REG_INDEX_BITS-1:0]}`.
  - The edge that writes reg 2^REG_INDEX_BITS-1 returns the FSM to IDLE.
- The single write port is owned by the clear engine in INIT and TCLR. An external write with `reg_access_we`=1 in either state is discarded, and `out_write_dropped`=1 in that cycle (registered, visible the following cycle).
- `out_ready` = (state==IDLE).
- `out_clear_ready` = (state==IDLE) && !`rst`. `in_clear_valid` is ignored in INIT and TCLR.
- `reg_access_rdata` is forced to 0 in these cases:
  - state==INIT, any address.
  - state==TCLR and raddr thread equals the latched thread.
- Otherwise `reg_access_rdata` = `mem[raddr]`.
- Writes to threads other than the latched one during TCLR are still dropped. Writeback must stall on `out_ready`=0.

## Timing
- Reset values:
  - state=INIT, `cnt`=0.
  - `out_ready`=0, `out_clear_ready`=0, `out_write_dropped`=0.
  - `reg_access_rdata`=0.
- Full clear after reset takes N edges with `rst`=0. With defaults N=256, so `out_ready` rises after the 256th edge.
- Thread clear takes 2^REG_INDEX_BITS edges after the accept edge (32 with defaults). `out_clear_ready` and `out_ready` are 0 from the cycle after accept until the final clear edge.
- Write latency is 1 edge; the written data is readable in the next cycle.
- Same-cycle write and read to the same address: behaviour depends on `REG_FILE_BYPASS_EN` (see Configuration).
- `rst` asserted mid-INIT or mid-TCLR: at the next edge the FSM enters INIT with `cnt`=0 and the full clear restarts. Any partial thread clear is abandoned.
- `out_write_dropped` is registered. It is high for exactly one cycle per dropped write and cleared by `rst`.

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - In IDLE, when `reg_access_we`=1 and waddr==raddr, `reg_access_rdata`=`reg_access_wdata` combinationally in the same cycle (write-to-read forwarding).
  - No forwarding for dropped writes.
- `REG_FILE_BYPASS_EN` undefined: a same-cycle read returns the old stored value, and the new value appears the cycle after the write edge.

## Test plan
- Reset then 256 idle cycles: `out_ready`=0 and rdata=0 until the 256th edge, then `out_ready`=1. Read all 256 addresses → 0.
- In IDLE, write 0xDEAD_BEEF_0000_0001 to `{3,7}`, read `{3,7}` next cycle → 0xDEAD_BEEF_0000_0001. Read `{2,7}` → 0.
- Same-cycle write 0x55 and read of `{1,4}`, after `{1,4}` was previously written 0x11:
  - With `REG_FILE_BYPASS_EN` → rdata=0x55.
  - Without the macro → rdata=0x11, then 0x55 the next cycle.
- Fill threads 2 and 5 with nonzero data, then request clear of thread 5:
  - Accepted on the first edge. `out_clear_ready`=0 for 32 cycles.
  - Reads of thread 5 return 0 throughout the clear.
  - Afterwards thread 5 is all 0 and thread 2 is unchanged.
- During a thread clear, assert `reg_access_we` to `{0,1}` with data 0x99: `out_write_dropped` pulses once, and `{0,1}` keeps its old value.
- Assert `rst` at cycle 10 of a thread clear: `out_ready`=0 for the next 256 cycles, then the whole array reads 0.
